// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller with a start/busy/done handshake.
// Two half adders plus an OR gate form a full adder. One result bit is produced
// per clock, LSB first, and a registered carry links the bit slots.
// Optional feature macro: SERADD_SUB_EN adds a `sub` input. When sub=1, B is
// inverted on load and the carry starts at 1, so the block computes A-B.
`timescale 1ns/1ps

module halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WIDTH-2:0]   r_res;      // bits already produced; the newest bit is at the MSB
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s0, w_c0, w_s, w_c1, w_c;
    logic               w_accept, w_last;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_init;

    // Operand conditioning for load: subtract computes A + ~B + 1
`ifdef SERADD_SUB_EN
    assign w_b_load = sub ? ~b_in : b_in;
    assign w_c_init = sub;
`else
    assign w_b_load = b_in;
    assign w_c_init = 1'b0;
`endif

    // Full adder: HA(A0,B0) then HA(sum,carry), with the two carries ORed together
    halfadder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]),  .o_s(w_s0), .o_c(w_c0));
    halfadder u_ha1 (.i_a(w_s0),   .i_b(r_carry), .o_s(w_s),  .o_c(w_c1));
    assign w_c = w_c0 | w_c1;

    // The DONE edge also accepts start. This gives back-to-back ops one WIDTH+1 cycles apart.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_full   = {w_s, r_res};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= w_b_load;
            r_res   <= '0;
            r_carry <= w_c_init;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_full[WIDTH-1:1];
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_full;
                r_cout <= w_c;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign sum_out = r_sum;
    assign cout    = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl. It runs directed and random ops and checks
// each result against plain integer arithmetic.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum_out;
`ifdef SERADD_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    // Result the model expects to be currently held on sum_out/cout
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERADD_SUB_EN
        .sub(sub),
`endif
        .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, sum}. Add is a (W+1)-bit sum. Subtract is A-B mod 2^W, and cout=1 means no borrow.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W-1:0] d;
        if (s) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    // One op: start for one edge, scramble the operands during RUN, optionally poke start at RUN cycle g
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input int g, input string tag);
        logic [W:0] e;
        int k, busyc, extra;
        bit stable;
        e = model(a, b, s);
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
`ifdef SERADD_SUB_EN
        sub = s;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
        k = 0; busyc = 0; stable = 1'b1;
        while (k < 40) begin
            @(negedge clk);
            k++;
            start = (k == g);
            if (k == g) begin a_in = W'($urandom); b_in = W'($urandom); end
            if (busy) busyc++;
            if (done) break;
            if (sum_out !== last_sum || cout !== last_cout) stable = 1'b0;
        end
        start = 1'b0;
        chk({tag, " latency"}, k, W + 1);
        chk({tag, " busy_cycles"}, busyc, W + 1);
        chk({tag, " no_partial_update"}, {31'd0, stable}, 32'd1);
        chk({tag, " sum"}, {24'd0, sum_out}, {24'd0, e[W-1:0]});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, e[W]});
        last_sum = e[W-1:0]; last_cout = e[W];
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " idle_after"}, {31'd0, busy}, 32'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({tag, " no_extra_done"}, extra, 0);
        chk({tag, " sum_holds"}, {24'd0, sum_out}, {24'd0, last_sum});
    endtask

    initial begin
        int k, d1, d2;
        bit s;
        logic [W-1:0] ra, rb;

        // Reset state
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst sum", {24'd0, sum_out}, 32'd0);
        chk("rst cout", {31'd0, cout}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed ops
        run_op(8'h00, 8'h00, 1'b0, 0, "zero");
        run_op(8'h5A, 8'h33, 1'b0, 0, "5a+33");
        run_op(8'hFF, 8'h01, 1'b0, 0, "wrap");
        run_op(8'h12, 8'h34, 1'b0, 3, "ignore_start");

        // Hold start high: the second op is accepted on the DONE edge
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; start = 1'b1;
        @(posedge clk);
        #1 a_in = 8'h80; b_in = 8'h80;
        k = 0; d1 = 0; d2 = 0;
        while (k < 40 && d2 == 0) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    chk("b2b first sum", {24'd0, sum_out}, 32'h30);
                    chk("b2b first cout", {31'd0, cout}, 32'd0);
                end else begin
                    d2 = k;
                    start = 1'b0;
                    chk("b2b second sum", {24'd0, sum_out}, 32'h00);
                    chk("b2b second cout", {31'd0, cout}, 32'd1);
                end
            end
        end
        start = 1'b0;
        chk("b2b first done edge", d1, W + 1);
        chk("b2b second done edge", d2, 2 * W + 2);
        last_sum = 8'h00; last_cout = 1'b1;
        @(negedge clk);
        chk("b2b idle after", {31'd0, busy}, 32'd0);

        // Random ops
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERADD_SUB_EN
            s = bit'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(ra, rb, s, 0, $sformatf("rand%0d", i));
        end

        // Reset during RUN aborts the op
        run_op(8'h5A, 8'h33, 1'b0, 0, "pre_abort");
        @(negedge clk);
        a_in = 8'hC3; b_in = 8'h7E; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort sum", {24'd0, sum_out}, 32'd0);
        chk("abort cout", {31'd0, cout}, 32'd0);
        last_sum = '0; last_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d1 = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) d1++;
        end
        chk("abort no done", d1, 0);
`ifdef SERADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 0, "post_abort_sub");
`else
        run_op(8'h05, 8'h07, 1'b0, 0, "post_abort_add");
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
